bp_be_branch_resolve: RTL and testbench

Branch resolution stage directly downstream of the integer pipe. It registers each resolved control-flow outcome, compares the computed next PC against the frontend's predicted next PC, and on a mispredict issues a single redirect to the frontend over a valid/ready handshake. While that redirect is outstanding it squashes younger wrong-path resolutions. It also flags misaligned branch targets for the exception path and keeps saturating branch and mispredict counters.

---
 rtl/bp_be_branch_resolve.sv | 73 +++++++
 tb/tb_bp_be_branch_resolve.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bp_be_branch_resolve.sv
// bp_be_branch_resolve: registers branch resolutions, issues one redirect per mispredict, flags misaligned targets, counts branches/mispredicts
// Ports: clk_i/reset_i (async active-high); en_i, branch_i, btaken_i, npc_i, pred_npc_i, instr_misaligned_v_i from the integer pipe;
// flush_i commit flush; redirect_ready_i/redirect_v_o/redirect_npc_o/redirect_taken_o frontend handshake;
// mispredict_flush_o, misaligned_o one-cycle pulses; stall_o while redirect pending; branch_count_o, mispredict_count_o saturating
module bp_be_branch_resolve #(
  parameter int vaddr_width_p = 39,
  parameter int ctr_width_p = 32
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic branch_i,
  input  logic btaken_i,
  input  logic [vaddr_width_p-1:0] npc_i,
  input  logic [vaddr_width_p-1:0] pred_npc_i,
  input  logic instr_misaligned_v_i,
  input  logic flush_i,
  input  logic redirect_ready_i,
  output logic redirect_v_o,
  output logic [vaddr_width_p-1:0] redirect_npc_o,
  output logic redirect_taken_o,
  output logic mispredict_flush_o,
  output logic misaligned_o,
  output logic stall_o,
  output logic [ctr_width_p-1:0] branch_count_o,
  output logic [ctr_width_p-1:0] mispredict_count_o
);
  typedef enum logic {e_idle, e_send} state_e;
  state_e r_state, w_state_n;
  logic [vaddr_width_p-1:0] r_npc;
  logic r_taken, r_mflush, r_misal;
  logic [ctr_width_p-1:0] r_bcnt, r_mcnt;
  logic w_accept, w_mispredict, w_misaligned;
  // anything arriving while a redirect is pending is wrong-path and dropped
  assign w_accept = en_i & branch_i & (r_state == e_idle) & ~flush_i;
  assign w_mispredict = w_accept & ~instr_misaligned_v_i & (npc_i != pred_npc_i);
  assign w_misaligned = w_accept & instr_misaligned_v_i;
  always_comb begin
    w_state_n = r_state;
    if (flush_i) w_state_n = e_idle;
    else if (r_state == e_idle) w_state_n = w_mispredict ? e_send : e_idle;
    else w_state_n = redirect_ready_i ? e_idle : e_send;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_npc <= '0;
      r_taken <= 1'b0;
      r_mflush <= 1'b0;
      r_misal <= 1'b0;
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_mflush <= w_mispredict;
      r_misal <= w_misaligned;
      if (w_mispredict) begin
        r_npc <= npc_i;
        r_taken <= btaken_i;
      end
      if (w_accept && ~&r_bcnt) r_bcnt <= r_bcnt + 1'b1;
      if (w_mispredict && ~&r_mcnt) r_mcnt <= r_mcnt + 1'b1;
    end
  end
  assign redirect_v_o = (r_state == e_send);
  assign stall_o = (r_state == e_send);
  assign redirect_npc_o = r_npc;
  assign redirect_taken_o = r_taken;
  assign mispredict_flush_o = r_mflush;
  assign misaligned_o = r_misal;
  assign branch_count_o = r_bcnt;
  assign mispredict_count_o = r_mcnt;
endmodule

// File: tb/tb_bp_be_branch_resolve.sv
// tb_bp_be_branch_resolve: directed and randomized checks of bp_be_branch_resolve against a behavioural model
module tb_bp_be_branch_resolve;
  localparam int va = 39;
  localparam int cw = 4;
  localparam int cmax = (1 << cw) - 1;
  logic clk = 0, reset_i = 0;
  logic en_i = 0, branch_i = 0, btaken_i = 0, instr_misaligned_v_i = 0, flush_i = 0, redirect_ready_i = 0;
  logic [va-1:0] npc_i = '0, pred_npc_i = '0;
  logic redirect_v_o, redirect_taken_o, mispredict_flush_o, misaligned_o, stall_o;
  logic [va-1:0] redirect_npc_o;
  logic [cw-1:0] branch_count_o, mispredict_count_o;
  int checks = 0, errors = 0;
  bit m_pend, m_taken, m_mfl, m_mis;
  logic [va-1:0] m_npc;
  int m_bc, m_mc;
  bp_be_branch_resolve #(.vaddr_width_p(va), .ctr_width_p(cw)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .branch_i(branch_i), .btaken_i(btaken_i),
    .npc_i(npc_i), .pred_npc_i(pred_npc_i), .instr_misaligned_v_i(instr_misaligned_v_i),
    .flush_i(flush_i), .redirect_ready_i(redirect_ready_i), .redirect_v_o(redirect_v_o),
    .redirect_npc_o(redirect_npc_o), .redirect_taken_o(redirect_taken_o),
    .mispredict_flush_o(mispredict_flush_o), .misaligned_o(misaligned_o), .stall_o(stall_o),
    .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o));
  always #5 clk = ~clk;
  task automatic idle_in();
    en_i = 0; branch_i = 0; btaken_i = 0; instr_misaligned_v_i = 0; flush_i = 0;
  endtask
  task automatic drive(input bit en, input bit br, input logic [va-1:0] npc, input logic [va-1:0] pred,
                       input bit tk, input bit mis, input bit fl, input bit rdy);
    en_i = en; branch_i = br; npc_i = npc; pred_npc_i = pred; btaken_i = tk;
    instr_misaligned_v_i = mis; flush_i = fl; redirect_ready_i = rdy;
  endtask
  task automatic cycle();
    bit acc;
    @(posedge clk);
    acc = en_i && branch_i && !m_pend && !flush_i;
    m_mfl = acc && !instr_misaligned_v_i && (npc_i != pred_npc_i);
    m_mis = acc && instr_misaligned_v_i;
    if (acc) m_bc = (m_bc == cmax) ? cmax : m_bc + 1;
    if (m_mfl) m_mc = (m_mc == cmax) ? cmax : m_mc + 1;
    if (flush_i || (m_pend && redirect_ready_i)) m_pend = 0;
    else if (m_mfl) begin m_pend = 1; m_npc = npc_i; m_taken = btaken_i; end
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    reset_i = 1; idle_in(); redirect_ready_i = 0;
    #2 reset_i = 0;
    m_pend = 0; m_npc = '0; m_taken = 0; m_mfl = 0; m_mis = 0; m_bc = 0; m_mc = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({redirect_v_o, redirect_npc_o, redirect_taken_o, mispredict_flush_o, misaligned_o, stall_o, branch_count_o, mispredict_count_o} !== '0) begin
      errors++; $display("FAIL reset outputs v=%b npc=%h bc=%0d mc=%0d, want all zero", redirect_v_o, redirect_npc_o, branch_count_o, mispredict_count_o);
    end
  endtask
  task automatic test_correct();
    do_reset();
    drive(1, 1, 39'h1000, 39'h1000, 1, 0, 0, 1); cycle(); idle_in();
    checks++;
    if (redirect_v_o !== 0 || branch_count_o !== 1 || mispredict_count_o !== 0) begin
      errors++; $display("FAIL correct_pred v=%b bc=%0d mc=%0d, want v=0 bc=1 mc=0", redirect_v_o, branch_count_o, mispredict_count_o);
    end
  endtask
  task automatic test_mispredict_ready();
    do_reset();
    drive(1, 1, 39'h2000, 39'h1004, 1, 0, 0, 1); cycle(); idle_in();
    checks++;
    if (redirect_v_o !== 1 || redirect_npc_o !== 39'h2000 || redirect_taken_o !== 1 || mispredict_flush_o !== 1 || stall_o !== 1 || mispredict_count_o !== 1) begin
      errors++; $display("FAIL mispredict_n1 v=%b npc=%h tk=%b mfl=%b st=%b mc=%0d, want 1 2000 1 1 1 1", redirect_v_o, redirect_npc_o, redirect_taken_o, mispredict_flush_o, stall_o, mispredict_count_o);
    end
    cycle();
    checks++;
    if (redirect_v_o !== 0 || mispredict_flush_o !== 0 || stall_o !== 0) begin
      errors++; $display("FAIL mispredict_n2 v=%b mfl=%b st=%b, want 0 0 0", redirect_v_o, mispredict_flush_o, stall_o);
    end
    drive(1, 1, 39'h3000, 39'h3000, 0, 0, 0, 1); cycle(); idle_in();
    checks++;
    if (branch_count_o !== 2) begin
      errors++; $display("FAIL accept_after_redirect bc=%0d, want 2", branch_count_o);
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    drive(1, 1, 39'h4000, 39'h4004, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (redirect_v_o !== 1 || redirect_npc_o !== 39'h4000 || redirect_taken_o !== 0) begin
        errors++; $display("FAIL backpressure_hold[%0d] v=%b npc=%h tk=%b, want 1 4000 0", i, redirect_v_o, redirect_npc_o, redirect_taken_o);
      end
      drive(1, 1, 39'h5000 + 39'(i), 39'h6000, 1, 0, 0, i == 3);
      cycle();
    end
    idle_in();
    checks++;
    if (redirect_v_o !== 0 || mispredict_count_o !== 1 || branch_count_o !== 1) begin
      errors++; $display("FAIL backpressure_end v=%b mc=%0d bc=%0d, want 0 1 1", redirect_v_o, mispredict_count_o, branch_count_o);
    end
  endtask
  task automatic test_misaligned();
    do_reset();
    drive(1, 1, 39'h1002, 39'h1004, 1, 1, 0, 1); cycle(); idle_in();
    checks++;
    if (misaligned_o !== 1 || redirect_v_o !== 0 || mispredict_flush_o !== 0) begin
      errors++; $display("FAIL misaligned_n1 mis=%b v=%b mfl=%b, want 1 0 0", misaligned_o, redirect_v_o, mispredict_flush_o);
    end
    cycle();
    checks++;
    if (misaligned_o !== 0 || branch_count_o !== 1 || mispredict_count_o !== 0) begin
      errors++; $display("FAIL misaligned_n2 mis=%b bc=%0d mc=%0d, want 0 1 0", misaligned_o, branch_count_o, mispredict_count_o);
    end
  endtask
  task automatic test_flush();
    do_reset();
    drive(1, 1, 39'h2000, 39'h1004, 1, 0, 1, 1); cycle(); idle_in();
    checks++;
    if (redirect_v_o !== 0 || mispredict_flush_o !== 0 || branch_count_o !== 0 || mispredict_count_o !== 0) begin
      errors++; $display("FAIL flush_coincident v=%b mfl=%b bc=%0d mc=%0d, want 0 0 0 0", redirect_v_o, mispredict_flush_o, branch_count_o, mispredict_count_o);
    end
    drive(1, 1, 39'h2000, 39'h1004, 1, 0, 0, 0); cycle(); idle_in();
    drive(0, 0, 39'h0, 39'h0, 0, 0, 1, 1); cycle(); idle_in();
    checks++;
    if (redirect_v_o !== 0 || stall_o !== 0 || mispredict_count_o !== 1) begin
      errors++; $display("FAIL flush_in_send v=%b st=%b mc=%0d, want 0 0 1", redirect_v_o, stall_o, mispredict_count_o);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 39'h7000, 39'h7004, 1, 0, 0, 0); cycle(); idle_in();
    #2 reset_i = 1; #1;
    checks++;
    if ({redirect_v_o, redirect_npc_o, redirect_taken_o, mispredict_flush_o, stall_o, mispredict_count_o, branch_count_o} !== '0) begin
      errors++; $display("FAIL async_reset v=%b npc=%h mfl=%b st=%b mc=%0d bc=%0d, want all zero", redirect_v_o, redirect_npc_o, mispredict_flush_o, stall_o, mispredict_count_o, branch_count_o);
    end
    reset_i = 0;
    m_pend = 0; m_npc = '0; m_taken = 0; m_mfl = 0; m_mis = 0; m_bc = 0; m_mc = 0;
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 39'h100 + 39'(i), 39'h4, i[0], 0, 0, 1);
      cycle();
    end
    idle_in(); cycle();
    checks++;
    if (mispredict_count_o !== cw'(cmax) || branch_count_o !== cw'(cmax)) begin
      errors++; $display("FAIL saturation mc=%0d bc=%0d, want %0d %0d", mispredict_count_o, branch_count_o, cmax, cmax);
    end
  endtask
  task automatic test_random();
    logic [va-1:0] a, b;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      a = va'({$urandom, $urandom});
      b = ($urandom_range(0, 2) == 0) ? a : va'({$urandom, $urandom});
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, a, b, $urandom_range(0, 1),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      cycle();
      checks++;
      if (redirect_v_o !== m_pend || stall_o !== m_pend || mispredict_flush_o !== m_mfl || misaligned_o !== m_mis ||
          branch_count_o !== cw'(m_bc) || mispredict_count_o !== cw'(m_mc) ||
          (m_pend && (redirect_npc_o !== m_npc || redirect_taken_o !== m_taken))) begin
        errors++;
        $display("FAIL random[%0d] v=%b st=%b mfl=%b mis=%b bc=%0d mc=%0d npc=%h tk=%b, want v=%b mfl=%b mis=%b bc=%0d mc=%0d npc=%h tk=%b",
                 i, redirect_v_o, stall_o, mispredict_flush_o, misaligned_o, branch_count_o, mispredict_count_o, redirect_npc_o, redirect_taken_o,
                 m_pend, m_mfl, m_mis, m_bc, m_mc, m_npc, m_taken);
      end
    end
    idle_in();
  endtask
  initial begin
    test_reset();
    test_correct();
    test_mispredict_ready();
    test_backpressure();
    test_misaligned();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
